// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t ASCII_CR = 8'h0D;
  localparam byte_t ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_feed_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered occupancy count; head byte is readable
// combinationally so a freshly pushed byte is usable the following cycle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  byte_t             push_data,
  input  logic              pop,
  output byte_t             head,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  byte_t             mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == (ADDR_W + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (ADDR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes and feeds async_transmitter one frame at a time, holding TxD_data.
// Define UART_TX_CRLF_EN to expand each LF into a CR frame followed by an LF frame.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              TxD_start,
  output logic [7:0]        TxD_data,
  input  logic              TxD_busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              idle
);

`ifdef UART_TX_CRLF_EN
  localparam bit CRLF_EN = 1'b1;
`else
  localparam bit CRLF_EN = 1'b0;
`endif

  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  byte_t          fifo_head;
  tx_feed_state_t state_reg, state_next;
  byte_t          txd_data_reg, txd_data_next;
  logic           txd_start_reg;
  logic           lf_pending_reg, lf_pending_next;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && !fifo_full;
  assign TxD_start = txd_start_reg;
  assign TxD_data  = txd_data_reg;
  assign idle      = fifo_empty && (state_reg == S_IDLE) && !TxD_busy && !lf_pending_reg;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      txd_data_reg   <= 8'h00;
      txd_start_reg  <= 1'b0;
      lf_pending_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      txd_data_reg   <= txd_data_next;
      txd_start_reg  <= (state_next == S_START);
      lf_pending_reg <= lf_pending_next;
    end
  end

  // WAIT_BUSY guards the cycle(s) before the transmitter reports busy.
  always_comb begin
    state_next      = state_reg;
    txd_data_next   = txd_data_reg;
    lf_pending_next = lf_pending_reg;
    pop             = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (!TxD_busy) begin
          if (CRLF_EN && lf_pending_reg) begin
            txd_data_next   = ASCII_LF;
            lf_pending_next = 1'b0;
            state_next      = S_START;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = S_START;
            if (CRLF_EN && (fifo_head == ASCII_LF)) begin
              txd_data_next   = ASCII_CR;
              lf_pending_next = 1'b1;
            end else begin
              txd_data_next = fifo_head;
            end
          end
        end
      end
      S_START:     state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (TxD_busy) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!TxD_busy) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: cycle vector table, a behavioural transmitter and a
// frame-level scoreboard driven by randomized producer traffic.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
`ifdef UART_TX_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       TxD_start;
  logic [7:0] TxD_data;
  logic       TxD_busy;
  logic [4:0] fifo_count;
  logic       idle;

  logic tbl_busy;
  logic model_en;
  logic model_busy = 1'b0;
  int   rise_dly, frame_len;
  int   rise_left = 0;
  int   busy_left = 0;

  int n_total = 0;
  int n_pass  = 0;

  logic       mon_en;
  int         pushed, popped, start_cnt, stall_cycles;
  bit         frame_active, saw_busy;
  logic [7:0] frame_data;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;
  assign TxD_busy = model_en ? model_busy : tbl_busy;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .TxD_start  (TxD_start),
    .TxD_data   (TxD_data),
    .TxD_busy   (TxD_busy),
    .fifo_count (fifo_count),
    .idle       (idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Transmitter model (no reset): busy rises rise_dly cycles after a start, lasts frame_len cycles.
  always @(posedge clk) begin
    if (model_en) begin
      if (rise_left > 0) begin
        if (rise_left == 1) begin model_busy <= 1'b1; busy_left <= frame_len; end
        rise_left <= rise_left - 1;
      end else if (busy_left > 0) begin
        if (busy_left == 1) model_busy <= 1'b0;
        busy_left <= busy_left - 1;
      end else if (TxD_start) begin
        if (rise_dly <= 1) begin model_busy <= 1'b1; busy_left <= frame_len; end
        else rise_left <= rise_dly - 1;
      end
    end
  end

  // Scoreboard: expected frame stream, queue occupancy and frame-hold rules.
  always @(negedge clk) begin
    if (mon_en) begin
      if (TxD_start) begin
        start_cnt++;
        chk("start_while_busy", TxD_busy, 0);
        chk("start_inside_frame", frame_active, 0);
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else chk("frame_data", TxD_data, exp_q.pop_front());
        got_q.push_back(TxD_data);
        if (!(CRLF && TxD_data == 8'h0A)) popped++;
        frame_active = 1'b1;
        saw_busy     = 1'b0;
        frame_data   = TxD_data;
      end else if (frame_active) begin
        chk("data_held", TxD_data, frame_data);
        if (TxD_busy) saw_busy = 1'b1;
        else if (saw_busy) frame_active = 1'b0;
      end
      chk("fifo_count", fifo_count, pushed - popped);
      chk("in_ready", in_ready, (pushed - popped) != DEPTH);
      if (in_valid && in_ready) begin
        pushed++;
        if (CRLF && in_data == 8'h0A) begin
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
        end else begin
          exp_q.push_back(in_data);
        end
      end
    end
  end

  task automatic mon_start();
    pushed = 0; popped = 0; start_cnt = 0; stall_cycles = 0;
    frame_active = 1'b0; saw_busy = 1'b0;
    exp_q.delete(); got_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 1000) begin @(negedge clk); n++; end
    chk("push_timeout", n >= 1000, 0);
    stall_cycles += n;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (n < 3000 && !(exp_q.size() == 0 && idle && !frame_active)) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n >= 3000, 0);
    step();
  endtask

  typedef struct {
    logic vld; logic [7:0] din; logic busy;
    logic start; logic [7:0] dout; logic [4:0] cnt; logic rdy; logic idl;
  } vec_t;
  localparam int NV = 19;
  vec_t vt[NV];

  initial begin
    logic [7:0] want[$];
    int n;

    // Single byte 0x41, then two back-to-back bytes with push+pop in one cycle.
    vt[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 5'd0, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 5'd0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 5'd0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 5'd0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h41, 5'd0, 1'b1, 1'b1};
    vt[9]  = '{1'b1, 8'h20, 1'b0, 1'b0, 8'h41, 5'd1, 1'b1, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 5'd1, 1'b1, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 5'd1, 1'b1, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 5'd1, 1'b1, 1'b0};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 5'd1, 1'b1, 1'b0};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 5'd1, 1'b1, 1'b0};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h20, 5'd0, 1'b1, 1'b0};
    vt[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 5'd0, 1'b1, 1'b0};
    vt[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 5'd0, 1'b1, 1'b0};
    vt[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 5'd0, 1'b1, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; tbl_busy = 1'b0;
    model_en = 1'b0; mon_en = 1'b0; rise_dly = 1; frame_len = 4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", TxD_start, 0);
    chk("rst_data", TxD_data, 8'h00);
    chk("rst_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    step();
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      in_valid = vt[i].vld; in_data = vt[i].din; tbl_busy = vt[i].busy;
      @(negedge clk);
      chk($sformatf("vec%0d_start", i), TxD_start, vt[i].start);
      chk($sformatf("vec%0d_data", i), TxD_data, vt[i].dout);
      chk($sformatf("vec%0d_count", i), fifo_count, vt[i].cnt);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].rdy);
      chk($sformatf("vec%0d_idle", i), idle, vt[i].idl);
      step();
    end
    in_valid = 1'b0; tbl_busy = 1'b0;
    model_en = 1'b1;
    repeat (2) step();

    // Burst of 20 bytes against a 16-deep queue.
    mon_start(); rise_dly = 1; frame_len = 10;
    for (int i = 0; i < 20; i++) push_byte(8'(i));
    drain();
    chk("burst_backpressure", stall_cycles > 0, 1);
    chk("burst_frames", got_q.size(), CRLF ? 21 : 20);

    // Push and pop in the same cycle at count 5.
    mon_start(); rise_dly = 1; frame_len = 15;
    for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
    chk("pp_setup_count", fifo_count, 5);
    n = 0;
    while (!TxD_busy && n < 50) begin @(negedge clk); n++; end
    while (TxD_busy && n < 100) begin @(negedge clk); n++; end
    chk("pp_wait_timeout", n >= 100, 0);
    step();
    in_valid = 1'b1; in_data = 8'h66;
    @(negedge clk);
    chk("pp_count_pop_cycle", fifo_count, 5);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pp_count_after", fifo_count, 5);
    chk("pp_start", TxD_start, 1);
    step();
    drain();

    // Slow busy rise: exactly one start while waiting for busy.
    mon_start(); rise_dly = 3; frame_len = 5;
    push_byte(8'h33);
    repeat (15) step();
    chk("slow_rise_starts", start_cnt, 1);
    drain();

    // "A\n" frame expansion.
    mon_start(); rise_dly = 1; frame_len = 4;
    push_byte(8'h41);
    push_byte(8'h0A);
    drain();
    if (CRLF) want = '{8'h41, 8'h0D, 8'h0A};
    else      want = '{8'h41, 8'h0A};
    chk("crlf_nframes", got_q.size(), want.size());
    for (int i = 0; i < want.size() && i < got_q.size(); i++)
      chk($sformatf("crlf_frame%0d", i), got_q[i], want[i]);

    // Randomized traffic, more than 3*DEPTH bytes per round so pointers wrap.
    for (int r = 0; r < 2; r++) begin
      mon_start();
      rise_dly  = $urandom_range(1, 3);
      frame_len = $urandom_range(1, 6);
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 2)) step();
        push_byte(($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom));
      end
      drain();
      chk("rand_frames_done", exp_q.size(), 0);
    end

    // Reset in WAIT_DONE with 4 bytes queued.
    mon_start(); rise_dly = 1; frame_len = 20;
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
    repeat (2) step();
    @(negedge clk);
    chk("pre_reset_count", fifo_count, 4);
    mon_en = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_data", TxD_data, 8'h00);
    chk("mid_rst_start", TxD_start, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_idle", idle, !TxD_busy);
    step();
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!TxD_start && n < 100) begin @(negedge clk); n++; end
    chk("post_rst_start_timeout", n >= 100, 0);
    chk("post_rst_start_busy", TxD_busy, 0);
    chk("post_rst_data", TxD_data, 8'h77);
    n = 0;
    step();
    while (!idle && n < 200) begin @(negedge clk); n++; end
    chk("post_rst_idle_timeout", n >= 200, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
